audio_tone_sequencer: RTL and testbench
=======================================

Name: audio_tone_sequencer

Overview:
- Upstream sample source for the DA2 audio output driver.
- Plays a programmable table of up to NUM_NOTES square-wave notes, one after another.
- Produces 12-bit unsigned samples at SAMPLE_HZ, derived from the board clock.
- Its sample bus feeds the driver's DATA1/DATA2; its sample strobe paces the driver's START.

Parameters:
- CLK_HZ, 100_000_000, frequency of CLOCK in Hz.
- SAMPLE_HZ, 20_000, output sample rate in Hz; DIV = CLK_HZ/SAMPLE_HZ (integer, ≥2).
- NUM_NOTES, 8, table depth; power of two, 2..16.
- MID, 12'd2048, idle/rest output level.
- AMP, 12'd1023, square-wave swing; requires MID+AMP ≤ 4095 and MID ≥ AMP.

Ports:
- CLOCK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins playback from entry 0.
- stop  in  1  one-cycle pulse; aborts playback.
- wr_en  in  1  table write strobe.
- wr_addr  in  log2(NUM_NOTES)  table entry index.
- wr_half_period  in  16  half-period in samples; 0 = rest.
- wr_duration  in  16  note length in samples; 0 = end-of-sequence marker.
- sample  out  12  current sample value.
- sample_valid  out  1  one-cycle pulse when sample updates (SAMPLE_HZ).
- busy  out  1  high in LOAD/PLAY.
- done  out  1  one-cycle pulse when the sequence ends naturally.
- note_idx  out  log2(NUM_NOTES)  entry currently playing.

Behaviour:
Reset (async, RST=1):
- Outputs: sample=MID, sample_valid=0, busy=0, done=0, note_idx=0.
- All table entries cleared (half_period=0, duration=0).
- Tick divider cleared; FSM enters IDLE.
- Reset mid-playback aborts immediately; there is no residual output.

Tick divider:
- Free-running counter 0..DIV-1; tick=1 for one cycle when count==DIV-1.
- sample_valid equals tick registered one cycle later.
- sample changes only on the cycle sample_valid rises.

FSM states: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - sample=MID, busy=0.
  - start → LOAD with idx=0.
- LOAD (exactly one cycle):
  - Reads entry[idx] into half_cnt_reload, dur_cnt, phase=1, half_cnt=half_period.
  - If duration==0 → DONE.
  - Otherwise → PLAY.
- PLAY, on each tick:
  - Output: sample = (half_period==0) ? MID : (phase ? MID+AMP : MID-AMP).
  - Then half_cnt decrements; on reaching 0, phase toggles and half_cnt reloads.
    - half_period=1 toggles every sample, giving SAMPLE_HZ/2.
  - dur_cnt decrements; on reaching 0, idx increments.
    - idx wrapped past NUM_NOTES-1 → DONE.
    - Otherwise → LOAD.
  - A note therefore lasts exactly duration samples.
- DONE (one cycle):
  - done=1, sample=MID on the next tick, → IDLE.

Boundary and conflict rules:
- start while busy → ignored.
- stop in LOAD/PLAY → IDLE next cycle; sample=MID on the next tick; done not pulsed.
- start and stop in the same cycle → stop wins.
- wr_en while busy → write ignored; table unchanged.
- wr_en in IDLE → entry written on that edge.
- wr_en and start in the same IDLE cycle → write takes effect, then LOAD reads the new value.
- Ticks keep running in IDLE; sample_valid pulses continuously so the DAC is refreshed with MID.
- note_idx shows idx during LOAD/PLAY and holds its last value otherwise until the next start.

Optional Feature:
- Macro: AUDIO_TONE_SEQ_LOOP_EN.
- Defined: reaching an end marker or wrapping past the last entry returns to LOAD with idx=0. done never pulses; only stop or RST ends playback.
  - Exception: if entry 0 itself has duration 0, the block goes to DONE to avoid a zero-length spin.
- Undefined: behaviour as specified above.

Test Plan:
- Reset check (use DIV=5000): assert RST mid-count → sample=2048, busy=0, all entries read back as zero-duration (start → done pulses 2 cycles later, busy=1 for exactly the LOAD cycle).
- Tick rate: idle for 20000 cycles → exactly 4 sample_valid pulses, spaced 5000 cycles; sample=2048 throughout.
- Single note:
  - Stimulus: entry0={hp=2, dur=8}, entry1 dur=0, then start.
  - Samples: 3071,3071,1025,1025,3071,3071,1025,1025.
  - Then done pulses and sample returns to 2048.
- Rest and sequence:
  - Stimulus: entry0={0,3}, entry1={1,4}, entry2 dur=0.
  - Samples: 2048×3, then 3071,1025,3071,1025.
  - note_idx goes 0→1; done after sample 7.
- Abort and conflicts:
  - stop during entry1 → busy falls next cycle, no done, next sample=2048.
  - start+stop same cycle in PLAY → stop wins.
  - wr_en during PLAY → entry unchanged on the next run.
- Loop (AUDIO_TONE_SEQ_LOOP_EN):
  - Stimulus: entry0={1,2}, entry1 dur=0.
  - Pattern 3071,1025 repeats for ≥3 iterations with no done pulse; stop ends playback.

Source files
------------

// File: rtl/audio_tone_sequencer.sv
// audio_tone_sequencer
// ---------------------------------------------------------------------------
// Upstream sample source for the DA2 audio output driver. Plays a table of up
// to NUM_NOTES square-wave notes back to back and emits one 12-bit unsigned
// sample per sample period (SAMPLE_HZ, derived from CLOCK by DIV).
//
// Optional feature macro: AUDIO_TONE_SEQ_LOOP_EN
//   defined   : an end marker or running past the last entry restarts at
//               entry 0; done never pulses (an end marker in entry 0 still
//               ends playback so an empty table cannot spin).
//   undefined : playback ends with a one-cycle done pulse.
//
// Ports
//   CLOCK           system clock
//   RST             asynchronous, active-high reset
//   start           one-cycle pulse, begins playback at entry 0 (IDLE only)
//   stop            one-cycle pulse, aborts playback (wins over start)
//   wr_en           table write strobe, honoured only while idle
//   wr_addr         table entry index
//   wr_half_period  half period in samples, 0 = rest
//   wr_duration     note length in samples, 0 = end-of-sequence marker
//   sample          current sample value
//   sample_valid    one-cycle strobe when sample updates
//   busy            high while loading or playing a note
//   done            one-cycle pulse when the sequence ends naturally
//   note_idx        entry currently playing (holds after playback)
//   state_dbg       current FSM state (IDLE=0, LOAD=1, PLAY=2, DONE=3)
//
// Strobe semantics: there is no backpressure. start/stop/wr_en are sampled on
// every rising edge they are high; sample_valid marks the single cycle in
// which a new sample value is presented and the consumer must take it then.
// ---------------------------------------------------------------------------
module audio_tone_sequencer #(
  parameter int          CLK_HZ    = 100_000_000,
  parameter int          SAMPLE_HZ = 20_000,
  parameter int          NUM_NOTES = 8,
  parameter logic [11:0] MID       = 12'd2048,
  parameter logic [11:0] AMP       = 12'd1023,
  localparam int         IDX_W     = $clog2(NUM_NOTES)
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [15:0]      wr_half_period,
  input  logic [15:0]      wr_duration,
  output logic [11:0]      sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx,
  output logic [1:0]       state_dbg
);

  localparam int               DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_NOTES - 1);
  localparam logic [11:0]      LVL_HI    = MID + AMP;
  localparam logic [11:0]      LVL_LO    = MID - AMP;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  logic [15:0]      hp_mem  [NUM_NOTES];
  logic [15:0]      dur_mem [NUM_NOTES];

  logic [IDX_W-1:0] idx;
  logic [15:0]      half_reload;
  logic [15:0]      half_cnt;
  logic [15:0]      dur_cnt;
  logic             phase;

  logic             play_tick;
  logic             note_end;
  logic             last_entry;
  logic             entry_is_marker;
  logic [11:0]      play_level;

  // Sample-rate divider: free running, also while idle, so the DAC keeps
  // being refreshed with MID.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A stop on a tick cycle suppresses that tick's note sample (MID instead).
  assign play_tick       = (state == S_PLAY) && tick && !stop;
  assign note_end        = play_tick && (dur_cnt == 16'd1);
  assign last_entry      = (idx == IDX_LAST);
  assign entry_is_marker = (dur_mem[idx] == 16'd0);
  assign play_level      = (half_reload == 16'd0) ? MID : (phase ? LVL_HI : LVL_LO);

  // Note table; writes only land while idle so a running sequence is stable.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        hp_mem[i]  <= '0;
        dur_mem[i] <= '0;
      end
    end else if (wr_en && (state == S_IDLE)) begin
      hp_mem[wr_addr]  <= wr_half_period;
      dur_mem[wr_addr] <= wr_duration;
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start && !stop) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (entry_is_marker) begin
`ifdef AUDIO_TONE_SEQ_LOOP_EN
          next_state = (idx == '0) ? S_DONE : S_LOAD;
`else
          next_state = S_DONE;
`endif
        end else begin
          next_state = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (note_end) begin
`ifdef AUDIO_TONE_SEQ_LOOP_EN
          next_state = S_LOAD;
`else
          next_state = last_entry ? S_DONE : S_LOAD;
`endif
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Note datapath: entry pointer, half-period and duration counters.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      idx         <= '0;
      half_reload <= '0;
      half_cnt    <= '0;
      dur_cnt     <= '0;
      phase       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) idx <= '0;
        end
        S_LOAD: begin
          half_reload <= hp_mem[idx];
          half_cnt    <= hp_mem[idx];
          dur_cnt     <= dur_mem[idx];
          phase       <= 1'b1;
`ifdef AUDIO_TONE_SEQ_LOOP_EN
          if (!stop && entry_is_marker) idx <= '0;
`endif
        end
        S_PLAY: begin
          if (play_tick) begin
            dur_cnt <= dur_cnt - 16'd1;
            // A rest (half period 0) never toggles.
            if (half_reload != 16'd0) begin
              if (half_cnt == 16'd1) begin
                phase    <= ~phase;
                half_cnt <= half_reload;
              end else begin
                half_cnt <= half_cnt - 16'd1;
              end
            end
            if (note_end) begin
              // Past the last entry idx is left on it (so note_idx holds).
              if (!last_entry) idx <= idx + 1'b1;
`ifdef AUDIO_TONE_SEQ_LOOP_EN
              else idx <= '0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output sample register; updates only on tick, together with the strobe.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      sample       <= MID;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick;
      if (tick) begin
        sample <= play_tick ? play_level : MID;
      end
    end
  end

  assign busy      = (state == S_LOAD) || (state == S_PLAY);
  assign done      = (state == S_DONE);
  assign note_idx  = idx;
  assign state_dbg = state;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Self-checking bench for audio_tone_sequencer.
// DIV is shrunk to 8 (CLK_HZ=160, SAMPLE_HZ=20) to keep runs short; the
// reference model assumes DIV >= 3 so LOAD cycles never swallow a note tick.
module tb_audio_tone_sequencer;

  localparam int CLK_HZ    = 160;
  localparam int SAMPLE_HZ = 20;
  localparam int DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int NUM_NOTES = 8;
  localparam int IDX_W     = 3;
  localparam int MIDV      = 2048;
  localparam int AMPV      = 1023;
`ifdef AUDIO_TONE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             CLOCK = 1'b0;
  logic             RST   = 1'b1;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [15:0]      wr_half_period = '0;
  logic [15:0]      wr_duration = '0;
  logic [11:0]      sample;
  logic             sample_valid;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] note_idx;
  logic [1:0]       state_dbg;

  always #5 CLOCK = ~CLOCK;

  audio_tone_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ),
    .NUM_NOTES (NUM_NOTES)
  ) dut (
    .CLOCK          (CLOCK),
    .RST            (RST),
    .start          (start),
    .stop           (stop),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_half_period (wr_half_period),
    .wr_duration    (wr_duration),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .done           (done),
    .note_idx       (note_idx),
    .state_dbg      (state_dbg)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Playback is a list of segments: a one-cycle table read, a note lasting a
  // number of sample ticks, or the one-cycle end pulse.
  localparam int K_GAP  = 0;
  localparam int K_NOTE = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int idx;
    int hp;
    int dur;
    int k;
  } seg_t;

  seg_t seg_q[$];
  int   m_hp  [NUM_NOTES];
  int   m_dur [NUM_NOTES];
  int   gen_i = 0;
  bit   gen_active = 1'b0;
  int   tcnt = 0;
  int   exp_sample = MIDV;
  bit   exp_sv = 1'b0;
  int   last_idx = 0;

  function automatic int level(input int hp, input int k);
    if (hp == 0) return MIDV;
    return (((k / hp) % 2) == 0) ? MIDV + AMPV : MIDV - AMPV;
  endfunction

  function automatic void push_seg(input int kind, input int idx, input int hp, input int dur);
    seg_t s;
    s.kind = kind; s.idx = idx; s.hp = hp; s.dur = dur; s.k = 0;
    seg_q.push_back(s);
  endfunction

  function automatic void expand();
    while (gen_active && seg_q.size() < 6) begin
      push_seg(K_GAP, gen_i, 0, 0);
      if (m_dur[gen_i] == 0) begin
        if (LOOP && gen_i != 0) gen_i = 0;
        else begin push_seg(K_DONE, gen_i, 0, 0); gen_active = 1'b0; end
      end else begin
        push_seg(K_NOTE, gen_i, m_hp[gen_i], m_dur[gen_i]);
        if (gen_i == NUM_NOTES - 1) begin
          if (LOOP) gen_i = 0;
          else begin push_seg(K_DONE, gen_i, 0, 0); gen_active = 1'b0; end
        end else begin
          gen_i++;
        end
      end
    end
  endfunction

  // Compare process: advances the model on every edge, checks every cycle.
  initial begin : model_cmp
    bit tick;
    bit exp_busy;
    bit exp_done;
    forever begin
      @(posedge CLOCK or posedge RST);
      if (RST) begin
        tcnt = 0; seg_q.delete(); gen_active = 1'b0; last_idx = 0;
        exp_sample = MIDV; exp_sv = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin m_hp[i] = 0; m_dur[i] = 0; end
      end else begin
        tick   = (tcnt == DIV - 1);
        tcnt   = tick ? 0 : tcnt + 1;
        exp_sv = tick;
        if (tick) begin
          if (seg_q.size() > 0 && seg_q[0].kind == K_NOTE && !stop)
            exp_sample = level(seg_q[0].hp, seg_q[0].k);
          else
            exp_sample = MIDV;
        end
        if (seg_q.size() == 0) begin
          if (wr_en) begin m_hp[wr_addr] = wr_half_period; m_dur[wr_addr] = wr_duration; end
          if (start && !stop) begin gen_i = 0; gen_active = 1'b1; expand(); end
        end else if (stop && seg_q[0].kind != K_DONE) begin
          seg_q.delete(); gen_active = 1'b0;
        end else begin
          if (seg_q[0].kind == K_NOTE) begin
            if (tick) begin
              seg_q[0].k = seg_q[0].k + 1;
              if (seg_q[0].k == seg_q[0].dur) void'(seg_q.pop_front());
            end
          end else begin
            void'(seg_q.pop_front());
          end
          expand();
        end
        if (seg_q.size() > 0) last_idx = seg_q[0].idx;
        exp_busy = (seg_q.size() > 0) && (seg_q[0].kind != K_DONE);
        exp_done = (seg_q.size() > 0) && (seg_q[0].kind == K_DONE);
        #2;
        check("m_sample", sample, exp_sample);
        check("m_sample_valid", sample_valid, exp_sv);
        check("m_busy", busy, exp_busy);
        check("m_done", done, exp_done);
        check("m_note_idx", note_idx, last_idx);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int got_q[$];
  int gidx_q[$];
  int lit_q[$];
  int lit_idx[$];

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic write_entry(input int a, input int hp, input int dur);
    @(negedge CLOCK);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_half_period = 16'(hp); wr_duration = 16'(dur);
    @(negedge CLOCK);
    wr_en = 1'b0;
  endtask

  // Leaves the bench at the negedge right after a sample strobe.
  task automatic wait_sv(input string name);
    int n;
    n = 0;
    do begin @(negedge CLOCK); n++; end while (!sample_valid && n < 4 * DIV);
    check({name, "_sv_wait"}, sample_valid, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK);
    start = 1'b0;
  endtask

  // Gathers samples until done has pulsed and one more sample has appeared.
  task automatic collect(input string name, input int budget);
    int n; int d; bit fin;
    got_q.delete(); gidx_q.delete(); n = 0; d = 0; fin = 1'b0;
    while (!fin && n < budget) begin
      @(negedge CLOCK); n++;
      if (sample_valid) begin
        got_q.push_back(int'(sample));
        gidx_q.push_back(int'(note_idx));
        if (d > 0) fin = 1'b1;
      end
      if (done) d++;
    end
    check({name, "_finished"}, fin, 1);
    check({name, "_done_pulses"}, d, 1);
  endtask

  task automatic cmp_lit(input string name, input bit with_idx);
    check({name, "_count"}, got_q.size(), lit_q.size());
    foreach (lit_q[i]) begin
      if (i < got_q.size()) begin
        check($sformatf("%s_s%0d", name, i), got_q[i], lit_q[i]);
        if (with_idx) check($sformatf("%s_idx%0d", name, i), gidx_q[i], lit_idx[i]);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int cnt; int last_c; int first_s; bit seen;
    cycles(3);
    RST = 1'b0;

    // Reset in the middle of playback with a non-empty table.
    write_entry(0, 2, 2);
    write_entry(1, 1, 4);
    wait_sv("rst_pre");
    pulse_start();
    wait_sv("rst_s1"); wait_sv("rst_s2"); wait_sv("rst_s3");
    check("rst_pre_sample", sample, 3071);
    check("rst_pre_idx", note_idx, 1);
    #3 RST = 1'b1;
    #1;
    check("rst_sample", sample, 2048);
    check("rst_busy", busy, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_done", done, 0);
    check("rst_idx", note_idx, 0);
    cycles(2);
    RST = 1'b0;
    // Table cleared: start reads an end marker, done two cycles after start.
    @(negedge CLOCK);
    pulse_start();
    check("rst_load_busy", busy, 1);
    check("rst_load_done", done, 0);
    @(negedge CLOCK);
    check("rst_end_busy", busy, 0);
    check("rst_end_done", done, 1);
    @(negedge CLOCK);
    check("rst_after_done", done, 0);

    // Idle tick rate: 4 strobes in 4*DIV cycles, DIV apart, all at MID.
    wait_sv("rate");
    cnt = 0; last_c = 0;
    for (int c = 1; c <= 4 * DIV; c++) begin
      @(negedge CLOCK);
      if (sample_valid) begin
        cnt++;
        check($sformatf("rate_gap%0d", cnt), c - last_c, DIV);
        check($sformatf("rate_mid%0d", cnt), sample, 2048);
        last_c = c;
      end
    end
    check("rate_count", cnt, 4);

    // Abort during entry 1.
    write_entry(0, 0, 3);
    write_entry(1, 1, 4);
    write_entry(2, 0, 0);
    wait_sv("abort");
    pulse_start();
    wait_sv("abort_s1"); wait_sv("abort_s2"); wait_sv("abort_s3"); wait_sv("abort_s4");
    check("abort_pre_idx", note_idx, 1);
    stop = 1'b1;
    @(negedge CLOCK);
    stop = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_idx_hold", note_idx, 1);
    cnt = 0; seen = 1'b0; first_s = -1;
    for (int c = 0; c < 2 * DIV; c++) begin
      if (done) cnt++;
      if (sample_valid && !seen) begin seen = 1'b1; first_s = int'(sample); end
      @(negedge CLOCK);
    end
    check("abort_no_done", cnt, 0);
    check("abort_next_sample", first_s, 2048);

    // start+stop together while playing: stop wins.
    wait_sv("ss");
    pulse_start();
    wait_sv("ss_s1"); wait_sv("ss_s2");
    start = 1'b1; stop = 1'b1;
    @(negedge CLOCK);
    start = 1'b0; stop = 1'b0;
    check("ss_play_busy", busy, 0);
    cnt = 0;
    for (int c = 0; c < 2 * DIV; c++) begin
      if (busy) cnt++;
      @(negedge CLOCK);
    end
    check("ss_stays_idle", cnt, 0);
    // start+stop together while idle.
    start = 1'b1; stop = 1'b1;
    @(negedge CLOCK);
    start = 1'b0; stop = 1'b0;
    check("ss_idle_busy", busy, 0);

`ifndef AUDIO_TONE_SEQ_LOOP_EN
    // Single note.
    write_entry(0, 2, 8);
    write_entry(1, 0, 0);
    wait_sv("single");
    pulse_start();
    collect("single", 200);
    lit_q = '{3071, 3071, 1025, 1025, 3071, 3071, 1025, 1025, 2048};
    cmp_lit("single", 1'b0);

    // Rest followed by a fast note.
    write_entry(0, 0, 3);
    write_entry(1, 1, 4);
    wait_sv("seq");
    pulse_start();
    collect("seq", 200);
    lit_q   = '{2048, 2048, 2048, 3071, 1025, 3071, 1025, 2048};
    lit_idx = '{0, 0, 1, 1, 1, 1, 2, 2};
    cmp_lit("seq", 1'b1);

    // Write while playing is dropped.
    wait_sv("wrp");
    pulse_start();
    wait_sv("wrp_s1"); wait_sv("wrp_s2");
    write_entry(1, 5, 2);
    cnt = 0;
    while (busy && cnt < 20 * DIV) begin @(negedge CLOCK); cnt++; end
    check("wrp_ended", busy, 0);
    wait_sv("wrp2");
    pulse_start();
    collect("wrp", 200);
    cmp_lit("wrp", 1'b1);

    // Write and start in the same idle cycle: LOAD sees the new entry.
    wait_sv("wrs");
    wr_en = 1'b1; wr_addr = '0; wr_half_period = 16'd1; wr_duration = 16'd2;
    start = 1'b1;
    @(negedge CLOCK);
    wr_en = 1'b0; start = 1'b0;
    collect("wrs", 200);
    lit_q   = '{3071, 1025, 3071, 1025, 3071, 1025, 2048};
    lit_idx = '{0, 1, 1, 1, 1, 2, 2};
    cmp_lit("wrs", 1'b1);
`else
    // Looping playback: pattern repeats, no done, stop ends it.
    write_entry(0, 1, 2);
    write_entry(1, 0, 0);
    wait_sv("loop");
    pulse_start();
    got_q.delete(); cnt = 0; last_c = 0;
    while (got_q.size() < 6 && last_c < 60 * DIV) begin
      @(negedge CLOCK); last_c++;
      if (done) cnt++;
      if (sample_valid) got_q.push_back(int'(sample));
    end
    lit_q = '{3071, 1025, 3071, 1025, 3071, 1025};
    cmp_lit("loop", 1'b0);
    check("loop_no_done", cnt, 0);
    check("loop_busy", busy, 1);
    stop = 1'b1;
    @(negedge CLOCK);
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
`endif

    cycles(2 * DIV);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout, expected sequence end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
